// File: rtl/IllusionDefines.sv
// IllusionDefines: shared enums for the command stream fetcher
package IllusionDefines;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetchState_t;
  typedef enum logic [1:0] {FREE, FILLING, FULL} bankState_t;
endpackage

// File: rtl/RAM_1R_1W.sv
// RAM_1R_1W: one write port, one asynchronous read port word memory
module RAM_1R_1W #(
  parameter int DEPTH = 64,
  parameter int SIZE = 128,
  localparam int AW = $clog2(SIZE)
) (
  input  logic             aClock,
  input  logic             aWriteEnable,
  input  logic [AW-1:0]    aWriteAddr,
  input  logic [DEPTH-1:0] aWriteData,
  input  logic [AW-1:0]    aReadAddr,
  output logic [DEPTH-1:0] anOutReadData
);
  logic [DEPTH-1:0] memory [SIZE];
  // contents are never cleared; only written words are ever read back
  always_ff @(posedge aClock)
    if (aWriteEnable) memory[aWriteAddr] <= aWriteData;
  assign anOutReadData = memory[aReadAddr];
endmodule

// File: rtl/command_stream_fetcher.sv
// command_stream_fetcher: double-buffered fetch of command lists from memory
module command_stream_fetcher
  import IllusionDefines::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BUFFER_SIZE = 64,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W = $clog2(BUFFER_SIZE),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic                  aClock,
  input  logic                  aReset,
  input  logic [ADDR_WIDTH-1:0] aCommandPointer,
  input  logic [CNT_W-1:0]      aCommandCount,
  input  logic                  anExecute,
  output logic                  anOutBusy,
  output logic [ADDR_WIDTH-1:0] anOutMemoryAddr,
  output logic                  anOutMemoryEnable,
  input  logic                  aMemoryAccept,
  input  logic [DATA_WIDTH-1:0] aMemoryData,
  input  logic                  aMemoryValid,
  input  logic [IDX_W-1:0]      aCommandIndex,
  input  logic                  aCommandRead,
  output logic [DATA_WIDTH-1:0] anOutCommandData,
  output logic                  anOutReady,
  output logic [CNT_W-1:0]      anOutReadyCount,
  input  logic                  aRelease,
  output logic                  anOutError
);
  localparam logic [CNT_W-1:0] BUF_CNT = CNT_W'(BUFFER_SIZE);
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);
  fetchState_t state;
  bankState_t bankState [2];
  logic [CNT_W-1:0] bankCount [2];
  logic fillBank, readBank;
  logic [ADDR_WIDTH-1:0] pointer;
  logic [CNT_W-1:0] count, issued, received, issuedNext, receivedNext;
  logic [3:0] outstanding;
  logic [DATA_WIDTH-1:0] ramData;
  logic start, badCount, fire, take, stray;

  assign anOutBusy = !(state == IDLE && bankState[fillBank] == FREE);
  assign start = anExecute && !anOutBusy;
  assign badCount = aCommandCount == '0 || aCommandCount > BUF_CNT;
  assign anOutMemoryEnable = state == FETCH && issued < count && outstanding < MAX_OUT;
  assign anOutMemoryAddr = pointer + ADDR_WIDTH'(issued);
  assign fire = anOutMemoryEnable && aMemoryAccept;
  // returns arriving while idle are leftovers of an aborted fetch and are dropped silently
  assign take = aMemoryValid && outstanding != '0;
  assign stray = aMemoryValid && outstanding == '0 && state != IDLE;
  assign issuedNext = issued + CNT_W'(fire);
  assign receivedNext = received + CNT_W'(take);
  assign anOutReady = bankState[readBank] == FULL;
  assign anOutReadyCount = anOutReady ? bankCount[readBank] : '0;

  RAM_1R_1W #(.DEPTH(DATA_WIDTH), .SIZE(2 * BUFFER_SIZE)) ram (
    .aClock       (aClock),
    .aWriteEnable (take),
    .aWriteAddr   ({fillBank, received[IDX_W-1:0]}),
    .aWriteData   (aMemoryData),
    .aReadAddr    ({readBank, aCommandIndex}),
    .anOutReadData(ramData)
  );

  // fetch FSM, bank bookkeeping and sticky error
  always_ff @(posedge aClock) begin
    if (!aReset) begin
      state <= IDLE;
      bankState[0] <= FREE;
      bankState[1] <= FREE;
      bankCount[0] <= '0;
      bankCount[1] <= '0;
      fillBank <= 1'b0;
      readBank <= 1'b0;
      pointer <= '0;
      count <= '0;
      issued <= '0;
      received <= '0;
      outstanding <= '0;
      anOutError <= 1'b0;
    end else begin
      issued <= issuedNext;
      received <= receivedNext;
      outstanding <= outstanding + 4'(fire) - 4'(take);
      if (stray) anOutError <= 1'b1;
      if (aRelease && anOutReady) begin
        bankState[readBank] <= FREE;
        readBank <= !readBank;
      end
      if (start && badCount) anOutError <= 1'b1;
      else if (start) begin
        pointer <= aCommandPointer;
        count <= aCommandCount;
        issued <= '0;
        received <= '0;
        outstanding <= '0;
        bankState[fillBank] <= FILLING;
        state <= FETCH;
        anOutError <= 1'b0;
      end else if (state == FETCH && issuedNext == count) state <= DRAIN;
      else if (state == DRAIN && receivedNext == count) begin
        state <= IDLE;
        bankState[fillBank] <= FULL;
        bankCount[fillBank] <= count;
        fillBank <= !fillBank;
      end
    end
  end

  // registered consumer read; out-of-range or not-ready reads return zero
  always_ff @(posedge aClock) begin
    if (!aReset) anOutCommandData <= '0;
    else if (aCommandRead)
      anOutCommandData <= (anOutReady && CNT_W'(aCommandIndex) < anOutReadyCount) ? ramData : '0;
  end
endmodule
